// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// stage_tag_t is the default-width tag layout; the top re-derives it from its own parameters.
package hazard_pkg;

    localparam int          HZ_REG_AW = 4;
    localparam int          HZ_N_SRC  = 2;
    localparam logic [31:0] PC_ADDR   = '1;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic                 valid;
        logic [HZ_REG_AW-1:0] wa;
        logic                 regwrite;
        logic                 memtoreg;
        logic                 pcsrc;
    } stage_tag_t;

endpackage

// File: rtl/hazard_tag_reg.sv
// Pipeline tag register with hold enable and synchronous clear (clear wins).
module hazard_tag_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller: tracks E/M/W destination tags and derives
// forwarding selects, stalls, flushes and the multi-cycle load freeze.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = HZ_REG_AW,
    parameter int N_SRC    = HZ_N_SRC,
    parameter int LOAD_LAT = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_SRC*REG_AW-1:0] src_d,
    input  logic [N_SRC-1:0]        src_valid_d,
    input  logic [REG_AW-1:0]       wa_d,
    input  logic                    regwrite_d,
    input  logic                    memtoreg_d,
    input  logic                    pcsrc_d,
    input  logic                    branch_taken_e,
    output logic [N_SRC*2-1:0]      forward_e,
    output logic                    stall_f,
    output logic                    stall_d,
    output logic                    stall_e,
    output logic                    stall_m,
    output logic                    flush_d,
    output logic                    flush_e
);

    localparam logic [REG_AW-1:0] PC = PC_ADDR[REG_AW-1:0];

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wa;
        logic              regwrite;
        logic              memtoreg;
        logic              pcsrc;
    } tag_t;

    typedef struct packed {
        logic [N_SRC-1:0][REG_AW-1:0] src;
        logic [N_SRC-1:0]             src_valid;
        tag_t                         t;
    } etag_t;

    // W never needs the load flag: ResultW is already the post-mux value.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] wa;
        logic              regwrite;
        logic              pcsrc;
    } wtag_t;

    logic [N_SRC-1:0][REG_AW-1:0] src_d_a;
    etag_t e_d, e_q;
    tag_t  m_q;
    wtag_t w_d, w_q;
    logic  d_valid;
    logic  mem_wait, m_load, cnt_run;
    logic  ldr_hit, ldr_stall, pcw_pend;
    logic [N_SRC-1:0][1:0] sel;

    assign src_d_a = src_d;

    assign e_d.src         = src_d_a;
    assign e_d.src_valid   = src_valid_d;
    assign e_d.t.valid     = d_valid;
    assign e_d.t.wa        = wa_d;
    assign e_d.t.regwrite  = regwrite_d;
    assign e_d.t.memtoreg  = memtoreg_d;
    assign e_d.t.pcsrc     = pcsrc_d;

    assign w_d = '{valid: m_q.valid, wa: m_q.wa, regwrite: m_q.regwrite, pcsrc: m_q.pcsrc};

    hazard_tag_reg #(.W($bits(etag_t))) u_tag_e (
        .clk (clk),
        .clr (reset | flush_e),
        .en  (~mem_wait),
        .d   (e_d),
        .q   (e_q)
    );

    hazard_tag_reg #(.W($bits(tag_t))) u_tag_m (
        .clk (clk),
        .clr (reset),
        .en  (~mem_wait),
        .d   (e_q.t),
        .q   (m_q)
    );

    // A frozen M stage retires nothing, so W sees a bubble each wait cycle.
    hazard_tag_reg #(.W($bits(wtag_t))) u_tag_w (
        .clk (clk),
        .clr (reset | mem_wait),
        .en  (1'b1),
        .d   (w_d),
        .q   (w_q)
    );

    assign m_load   = m_q.valid & m_q.memtoreg;
    assign mem_wait = m_load & cnt_run & ~reset;

    generate
        if (LOAD_LAT == 0) begin : g_no_wait
            assign cnt_run = 1'b0;
        end else begin : g_wait
            localparam int CW = $clog2(LOAD_LAT + 1);
            logic [CW-1:0] wait_cnt;

            always_ff @(posedge clk) begin
                if (reset)
                    wait_cnt <= '0;
                else if (mem_wait)
                    wait_cnt <= wait_cnt + CW'(1);
                else
                    wait_cnt <= '0;
            end

            assign cnt_run = wait_cnt < CW'(LOAD_LAT);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset)
            d_valid <= 1'b0;
        else if (!mem_wait)
            d_valid <= ~flush_d;
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            sel[i] = FWD_RF;
            if (!reset && e_q.src_valid[i] && e_q.src[i] != PC) begin
                if (m_q.valid && m_q.regwrite && m_q.wa == e_q.src[i])
                    sel[i] = FWD_M;
                else if (w_q.valid && w_q.regwrite && w_q.wa == e_q.src[i])
                    sel[i] = FWD_W;
            end
        end
    end

    assign forward_e = sel;

    always_comb begin
        ldr_hit = 1'b0;
        for (int i = 0; i < N_SRC; i++)
            if (src_valid_d[i] && src_d_a[i] == e_q.t.wa)
                ldr_hit = 1'b1;
    end

    assign ldr_stall = e_q.t.valid & e_q.t.memtoreg & ldr_hit;
    assign pcw_pend  = pcsrc_d | (e_q.t.valid & e_q.t.pcsrc) | (m_q.valid & m_q.pcsrc);

    always_comb begin
        stall_f = ldr_stall | pcw_pend;
        stall_d = ldr_stall;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_e = ldr_stall | branch_taken_e;
        flush_d = pcw_pend | (w_q.valid & w_q.pcsrc) | branch_taken_e;
        // Freeze: the branch stays in E, so its flush resolves once the wait ends.
        if (mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_e = 1'b0;
            flush_d = 1'b0;
        end
        if (reset) begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            stall_e = 1'b0;
            stall_m = 1'b0;
            flush_e = 1'b0;
            flush_d = pcsrc_d;
        end
    end

endmodule
